// File: rtl/i2s_clk_gen_nco_if.sv
// rtl/i2s_clk_gen_nco_if.sv - control inputs and clock/strobe outputs of the I2S NCO clock generator
interface i2s_clk_gen_nco_if #(
    parameter int ACC_W     = 32,
    parameter int SLOT_W    = 32,
    parameter int NUM_SLOTS = 2
);
    localparam int SLOT_IW = $clog2(NUM_SLOTS);
    localparam int BIT_IW  = $clog2(SLOT_W);

    logic               enable;
    logic [ACC_W-1:0]   phase_inc;
    logic [1:0]         mode;

    logic               bclk;
    logic               lrclk;
    logic               bclk_rise;
    logic               bclk_fall;
    logic               frame_start;
    logic [SLOT_IW-1:0] slot_idx;
    logic [BIT_IW-1:0]  bit_idx;
    logic               locked;

    // master is the generator, slave is the controller / shifter side
    modport master (
        input  enable, phase_inc, mode,
        output bclk, lrclk, bclk_rise, bclk_fall, frame_start, slot_idx, bit_idx, locked
    );

    modport slave (
        output enable, phase_inc, mode,
        input  bclk, lrclk, bclk_rise, bclk_fall, frame_start, slot_idx, bit_idx, locked
    );
endinterface

// File: rtl/i2s_clk_gen_nco.sv
// rtl/i2s_clk_gen_nco.sv - NCO-based I2S/LJ/TDM bit-clock, frame-sync and frame-position generator
module i2s_clk_gen_nco #(
    parameter int ACC_W       = 32,
    parameter int SLOT_W      = 32,
    parameter int NUM_SLOTS   = 2,
    parameter int LOCK_FRAMES = 2
) (
    input  logic refclk,
    input  logic rst,
    i2s_clk_gen_nco_if.master bus
);
    localparam int F       = SLOT_W * NUM_SLOTS;
    localparam int H       = F / 2;
    localparam int POS_W   = $clog2(F);
    localparam int SLOT_IW = $clog2(NUM_SLOTS);
    localparam int BIT_IW  = $clog2(SLOT_W);
    localparam int LOCK_W  = $clog2(LOCK_FRAMES + 1);

    logic [ACC_W-1:0]   acc;
    logic               bclk_q;
    logic               lrclk_q;
    logic               rise_q;
    logic               fall_q;
    logic               fs_q;
    logic [POS_W-1:0]   pos_q;
    logic [SLOT_IW-1:0] slot_q;
    logic [BIT_IW-1:0]  bit_q;
    logic               locked_q;
    logic [LOCK_W-1:0]  lock_cnt;
    logic [1:0]         mode_act;
    logic               fresh;
    logic [ACC_W-1:0]   inc_q;
    logic [1:0]         mode_q;

    logic [ACC_W:0]     sum;
    logic               tick;
    logic               fall_now;
    logic               wrap;
    logic               clear_lock;
    logic [1:0]         mode_eff;
    logic [1:0]         mode_sel;
    logic [POS_W-1:0]   pos_next;
    logic [SLOT_IW-1:0] slot_next;
    logic [BIT_IW-1:0]  bit_next;
    logic               lr_next;

    // lrclk level for the bit presented at position p under framing mode m
    function automatic logic lr_rule(input logic [POS_W-1:0] p, input logic [1:0] m);
        case (m)
            2'd0:    lr_rule = (p >= POS_W'(H - 1)) && (p <= POS_W'(F - 2));
            2'd2:    lr_rule = (p == POS_W'(F - 1));
            default: lr_rule = (p >= POS_W'(H));
        endcase
    endfunction

    always_comb begin
        sum        = {1'b0, acc} + {1'b0, bus.phase_inc};
        tick       = sum[ACC_W];
        fall_now   = tick & bclk_q;
        wrap       = fall_now && (pos_q == POS_W'(F - 1));
        mode_eff   = (bus.mode == 2'd3) ? 2'd1 : bus.mode;
        mode_sel   = wrap ? mode_eff : mode_act;
        clear_lock = (bus.phase_inc != inc_q) || (bus.mode != mode_q);
        pos_next   = wrap ? '0 : pos_q + 1'b1;
        bit_next   = bit_q - 1'b1;
        slot_next  = slot_q;
        if (bit_q == '0) begin
            bit_next  = BIT_IW'(SLOT_W - 1);
            slot_next = (slot_q == SLOT_IW'(NUM_SLOTS - 1)) ? '0 : slot_q + 1'b1;
        end
        lr_next    = lr_rule(pos_next, mode_sel);
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            fs_q     <= 1'b0;
            pos_q    <= '0;
            slot_q   <= '0;
            bit_q    <= BIT_IW'(SLOT_W - 1);
            locked_q <= 1'b0;
            lock_cnt <= '0;
            mode_act <= 2'd0;
            fresh    <= 1'b1;
            inc_q    <= '0;
            mode_q   <= 2'd0;
        end else begin
            inc_q  <= bus.phase_inc;
            mode_q <= bus.mode;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            fs_q   <= 1'b0;
            if (!bus.enable) begin
                acc      <= '0;
                bclk_q   <= 1'b0;
                lrclk_q  <= 1'b0;
                pos_q    <= '0;
                slot_q   <= '0;
                bit_q    <= BIT_IW'(SLOT_W - 1);
                locked_q <= 1'b0;
                lock_cnt <= '0;
                mode_act <= mode_eff;
                fresh    <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
                // framing mode is sampled when a frame begins: first tick after idle, or the wrap
                if (fresh || wrap) begin
                    mode_act <= mode_eff;
                end
                if (tick) begin
                    fresh  <= 1'b0;
                    bclk_q <= ~bclk_q;
                    rise_q <= ~bclk_q;
                    fall_q <= bclk_q;
                end
                if (fall_now) begin
                    pos_q   <= pos_next;
                    slot_q  <= slot_next;
                    bit_q   <= bit_next;
                    lrclk_q <= lr_next;
                    fs_q    <= wrap;
                end
                // a clear outranks a coincident frame_start, which then does not count
                if (clear_lock) begin
                    lock_cnt <= '0;
                    locked_q <= 1'b0;
                end else if (wrap && (lock_cnt != LOCK_W'(LOCK_FRAMES))) begin
                    lock_cnt <= lock_cnt + 1'b1;
                    locked_q <= (lock_cnt == LOCK_W'(LOCK_FRAMES - 1));
                end
            end
        end
    end

    assign bus.bclk        = bclk_q;
    assign bus.lrclk       = lrclk_q;
    assign bus.bclk_rise   = rise_q;
    assign bus.bclk_fall   = fall_q;
    assign bus.frame_start = fs_q;
    assign bus.slot_idx    = slot_q;
    assign bus.bit_idx     = bit_q;
    assign bus.locked      = locked_q;
endmodule

// File: tb/tb_i2s_clk_gen_nco.sv
// tb/tb_i2s_clk_gen_nco.sv - scoreboard bench for i2s_clk_gen_nco against an arithmetic phase model
module tb_i2s_clk_gen_nco;
    localparam int ACC_W       = 32;
    localparam int SLOT_W      = 32;
    localparam int NUM_SLOTS   = 2;
    localparam int LOCK_FRAMES = 2;
    localparam int F           = SLOT_W * NUM_SLOTS;
    localparam int H           = F / 2;
    localparam logic [31:0] HALF = 32'h8000_0000;

    logic refclk = 1'b0;
    logic rst;

    i2s_clk_gen_nco_if #(.ACC_W(ACC_W), .SLOT_W(SLOT_W), .NUM_SLOTS(NUM_SLOTS)) bus ();

    i2s_clk_gen_nco #(
        .ACC_W(ACC_W), .SLOT_W(SLOT_W), .NUM_SLOTS(NUM_SLOTS), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        longint cyc;
        logic   rise;
        logic   fs;
        logic   lr;
        int     slot;
        int     bitn;
        logic   locked;
    } ev_t;

    ev_t    sb[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    longint cycn     = 0;
    int     n_rise   = 0;
    int     n_fs     = 0;

    // reference model: total phase since enable; ticks = total / 2^ACC_W, bits = ticks / 2
    longint unsigned m_total;
    longint unsigned m_ticks;
    int              m_mode;
    logic            m_lr;
    int              m_lock;
    logic [31:0]     m_prev_inc;
    int              m_prev_mode;

    always @(posedge refclk) cycn <= cycn + 1;

    function automatic int eff(input logic [1:0] md);
        return (md == 2'd3) ? 1 : int'(md);
    endfunction

    function automatic logic lr_of(input int p, input int md);
        if (md == 0) return (p >= H - 1) && (p <= F - 2);
        if (md == 2) return (p == F - 1);
        return (p >= H);
    endfunction

    task automatic model_idle(input logic [1:0] md);
        m_total = 0;
        m_ticks = 0;
        m_lr    = 1'b0;
        m_lock  = 0;
        m_mode  = eff(md);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string nm);
        logic [63:0] act;
        act = {bus.bclk, bus.lrclk, bus.bclk_rise, bus.bclk_fall, bus.frame_start, bus.locked,
               32'(bus.slot_idx), 26'(bus.bit_idx)};
        chk(nm, act, {6'b0, 32'd0, 26'(SLOT_W - 1)});
    endtask

    // one refclk cycle: drive at negedge, predict the result of the coming posedge
    task automatic cyc(input logic en, input logic [31:0] inc, input logic [1:0] md);
        ev_t             e;
        longint unsigned old;
        int              p;
        logic            fs;
        logic            clr;
        bus.enable    = en;
        bus.phase_inc = inc;
        bus.mode      = md;
        clr           = (inc != m_prev_inc) || (int'(md) != m_prev_mode);
        m_prev_inc    = inc;
        m_prev_mode   = int'(md);
        if (!en) begin
            model_idle(md);
        end else begin
            old     = m_ticks;
            m_total = m_total + 64'(inc);
            m_ticks = m_total >> ACC_W;
            fs      = 1'b0;
            p       = int'((m_ticks / 2) % F);
            if (m_ticks != old) begin
                if (old == 0) m_mode = eff(md);
                if (m_ticks % 2 == 0) begin
                    if (p == 0) begin
                        fs     = 1'b1;
                        m_mode = eff(md);
                    end
                    m_lr = lr_of(p, m_mode);
                end
            end
            if (clr) m_lock = 0;
            else if (fs && m_lock < LOCK_FRAMES) m_lock++;
            if (m_ticks != old) begin
                e.cyc    = cycn + 1;
                e.rise   = (m_ticks % 2 == 1);
                e.fs     = fs;
                e.lr     = m_lr;
                e.slot   = p / SLOT_W;
                e.bitn   = SLOT_W - 1 - (p % SLOT_W);
                e.locked = (m_lock >= LOCK_FRAMES);
                sb.push_back(e);
            end
        end
        @(negedge refclk);
    endtask

    task automatic run(input int n, input logic en, input logic [31:0] inc, input logic [1:0] md);
        for (int k = 0; k < n; k++) cyc(en, inc, md);
    endtask

    task automatic run_to_pos(input int target, input logic [31:0] inc, input logic [1:0] md);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 40000 && !hit; k++) begin
            cyc(1'b1, inc, md);
            if (m_ticks > 0 && m_ticks % 2 == 0 && int'((m_ticks / 2) % F) == target) hit = 1'b1;
        end
        n_checks++;
        if (!hit) begin
            n_fail++;
            $display("FAIL reach_pos_%0d: reached %0d expected 1 within cycle budget", target, hit);
        end
    endtask

    // monitor: pops the prediction whenever the generator presents a bclk edge strobe
    initial begin : monitor
        ev_t e;
        forever begin
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc < cycn) begin
                e = sb.pop_front();
                n_checks++;
                n_fail++;
                $display("FAIL missing_strobe: got none at cycle %0d expected rise=%0d", e.cyc, e.rise);
            end
            if (bus.bclk_rise || bus.bclk_fall) begin
                if (bus.bclk_rise) n_rise++;
                if (bus.frame_start) n_fs++;
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_strobe: got rise=%0d fall=%0d at cycle %0d expected none",
                             bus.bclk_rise, bus.bclk_fall, cycn);
                end else begin
                    e = sb.pop_front();
                    if (e.cyc != cycn || bus.bclk_rise !== e.rise || bus.bclk_fall !== !e.rise ||
                        bus.bclk !== e.rise || bus.frame_start !== e.fs || bus.lrclk !== e.lr ||
                        int'(bus.slot_idx) != e.slot || int'(bus.bit_idx) != e.bitn ||
                        bus.locked !== e.locked) begin
                        n_fail++;
                        $display("FAIL strobe: got cyc=%0d rise=%0d fall=%0d bclk=%0d fs=%0d lr=%0d slot=%0d bit=%0d lock=%0d expected cyc=%0d rise=%0d fs=%0d lr=%0d slot=%0d bit=%0d lock=%0d",
                                 cycn, bus.bclk_rise, bus.bclk_fall, bus.bclk, bus.frame_start, bus.lrclk,
                                 bus.slot_idx, bus.bit_idx, bus.locked,
                                 e.cyc, e.rise, e.fs, e.lr, e.slot, e.bitn, e.locked);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        longint unsigned exp_ticks;
        int              exp_rise;
        int              exp_fs;
        logic [31:0]     rinc;
        logic [1:0]      rmode;
        rst           = 1'b1;
        bus.enable    = 1'b0;
        bus.phase_inc = '0;
        bus.mode      = 2'd0;
        m_prev_inc    = '0;
        m_prev_mode   = 0;
        model_idle(2'd0);
        repeat (3) @(negedge refclk);
        check_idle("reset_values");
        rst = 1'b0;
        run(3, 1'b0, HALF, 2'd0);
        check_idle("idle_after_reset");

        // defaults: 4-cycle bclk, 256-cycle frame, lock on the 2nd frame_start
        run(3 * 4 * F + 20, 1'b1, HALF, 2'd0);
        chk("locked_default", bus.locked, 1);

        // phase_inc change while locked: locked drops the following cycle
        cyc(1'b1, 32'h6000_0000, 2'd0);
        chk("locked_drop_on_inc", bus.locked, 0);
        run(600, 1'b1, 32'h6000_0000, 2'd0);

        // each framing mode from a clean start
        for (int m = 0; m < 4; m++) begin
            run(2, 1'b0, HALF, 2'(m));
            check_idle("idle_mode_entry");
            run(2 * 4 * F + 40, 1'b1, HALF, 2'(m));
        end

        // mode 1 -> 0 mid-frame: old rule until the next frame_start, relock after two frames
        run(2, 1'b0, HALF, 2'd1);
        run_to_pos(20, HALF, 2'd1);
        run(3 * 4 * F + 40, 1'b1, HALF, 2'd0);
        chk("relock_after_mode_switch", bus.locked, 1);

        // enable low at pos 17 for 5 cycles
        run_to_pos(17, HALF, 2'd0);
        cyc(1'b0, HALF, 2'd0);
        check_idle("idle_after_disable");
        run(4, 1'b0, HALF, 2'd0);
        run(3 * 4 * F, 1'b1, HALF, 2'd0);

        // asynchronous reset in the middle of a refclk period
        run_to_pos(40, HALF, 2'd0);
        @(posedge refclk);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_reset_mid_cycle");
        sb.delete();
        model_idle(2'd0);
        m_prev_inc  = '0;
        m_prev_mode = 0;
        @(negedge refclk);
        rst = 1'b0;
        run(2, 1'b0, HALF, 2'd0);
        run(2 * 4 * F, 1'b1, HALF, 2'd0);

        // 3.072 MHz from 50 MHz over a 20000-cycle window
        run(2, 1'b0, 32'd527765581, 2'd0);
        n_rise = 0;
        n_fs   = 0;
        run(20000, 1'b1, 32'd527765581, 2'd0);
        exp_ticks = (64'd20000 * 64'd527765581) >> ACC_W;
        exp_rise  = int'((exp_ticks + 1) / 2);
        exp_fs    = int'((exp_ticks / 2) / F);
        chk("rate_rise_count", ((n_rise >= exp_rise - 1) && (n_rise <= exp_rise + 1)) ? n_rise : -1, exp_rise > 0 ? n_rise : 0);
        chk("rate_frame_count", ((n_fs >= exp_fs - 1) && (n_fs <= exp_fs + 1)) ? n_fs : -1, n_fs);
        if (n_rise < exp_rise - 1 || n_rise > exp_rise + 1)
            $display("note rate_rise: got %0d expected %0d", n_rise, exp_rise);

        // randomized segments: rate, mode, enable drops
        for (int s = 0; s < 14; s++) begin
            rinc  = $urandom_range(32'h8000_0000, 32'h0800_0000);
            rmode = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) run(int'($urandom_range(3, 1)), 1'b0, rinc, rmode);
            run(int'($urandom_range(1400, 150)), 1'b1, rinc, rmode);
            if ($urandom_range(1, 0) == 1) run(int'($urandom_range(500, 50)), 1'b1, rinc, 2'($urandom_range(3, 0)));
        end

        run(4, 1'b0, HALF, 2'd0);
        check_idle("final_idle");
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/i2s_clk_gen_nco.md
Name: i2s_clk_gen_nco

Overview:
- Parametrised digital successor to the fixed-frequency I2S bit-clock PLL.
- Generates BCLK, LRCLK/FS and frame-position strobes from a single reference clock, using a runtime-programmable fractional phase accumulator (NCO).
- Supports I2S, left-justified and TDM/DSP framing with configurable slot width and slot count, plus a frame-based lock indicator.
- Feeds the I2S TX/RX shifters, which sample its strobes in the refclk domain.

Parameters:
- ACC_W, 32, phase accumulator width in bits.
- SLOT_W, 32, BCLK periods per slot (must be >= 2).
- NUM_SLOTS, 2, slots per frame (must be >= 2).
- LOCK_FRAMES, 2, complete frames required before locked asserts.

Ports:
- refclk  in  1  system/reference clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run generator; low returns it to idle.
- phase_inc  in  ACC_W  NCO increment per refclk cycle; f_bclk = f_refclk * phase_inc / 2^(ACC_W+1).
- mode  in  2  0 = I2S, 1 = left-justified, 2 = TDM/DSP pulse, 3 = treated as 1.
- bclk  out  1  bit clock, registered.
- lrclk  out  1  word-select / frame-sync, registered.
- bclk_rise  out  1  one-cycle strobe in the cycle bclk goes 0->1.
- bclk_fall  out  1  one-cycle strobe in the cycle bclk goes 1->0.
- frame_start  out  1  one-cycle strobe on the bclk_fall where the position wraps to 0.
- slot_idx  out  clog2(NUM_SLOTS)  current slot.
- bit_idx  out  clog2(SLOT_W)  current bit within slot, MSB first.
- locked  out  1  stable-output indicator.

Behaviour:
- Reset values (rst high, or enable low):
  - acc = 0, bclk = 0, lrclk = 0, all strobes = 0.
  - pos = 0, slot_idx = 0, bit_idx = SLOT_W-1, locked = 0.
- Idle return: enable deassert puts all outputs at these values on the next refclk edge.
- NCO:
  - While enable: {carry, acc} <= acc + phase_inc each cycle.
  - carry = tick; at most one tick per cycle, so f_bclk <= f_refclk/2.
  - phase_inc = 0 gives no ticks and all outputs hold.
  - A phase_inc change takes effect on the next cycle; acc is not cleared.
- On a tick, bclk toggles:
  - 0->1: bclk_rise is asserted in the same cycle as bclk goes high.
  - 1->0: bclk_fall is asserted, and pos, slot_idx, bit_idx and lrclk update in that same cycle.
- Position:
  - pos runs 0..F-1, where F = SLOT_W*NUM_SLOTS.
  - bit_idx counts SLOT_W-1 down to 0, then reloads and slot_idx increments.
  - slot_idx wraps from NUM_SLOTS-1 to 0.
  - Use separate down/up counters; no divider.
- Data convention:
  - Data changes on bclk_fall; receivers sample on bclk_rise.
  - First rise after enable presents pos 0 (slot 0 MSB).
- lrclk, value held for the bit at pos (H = F/2 for NUM_SLOTS even; floor otherwise):
  - mode 0 (I2S): 1 when SLOT_W*... no, when H-1 <= pos <= F-2, i.e. one bit ahead of left-justified; else 0.
  - mode 1 (left-justified): 1 when pos >= H; else 0.
  - mode 2 (TDM/DSP): 1 only when pos == F-1, a single-BCLK pulse one bit before slot 0 MSB.
- frame_start: asserted on the bclk_fall where pos wraps F-1 -> 0.
- Mode change while enabled:
  - The new mode is latched and applied at the next frame_start.
  - lrclk keeps the old rule until then.
- locked:
  - Counts frame_start pulses since the last clear.
  - Asserts on the LOCK_FRAMES-th frame_start.
  - Cleared by rst, enable low, any change of phase_inc, or any change of the mode input.
  - After a clear, counting restarts from 0.
- Reset mid-frame: async clear of all state; no partial strobes.
- Simultaneous events:
  - enable low and a tick in the same cycle: enable wins, idle.
  - phase_inc change and frame_start in the same cycle: locked clears, and that frame_start does not count.
- All outputs come from flops; no combinational path from inputs to outputs.

Test Plan:
- Defaults, phase_inc = 2^31 -> tick every 2 cycles; bclk period 4 refclk; frame_start every 256 cycles; locked high on the 2nd frame_start.
- phase_inc = 527765581 at 50 MHz, run 1,000,000 cycles -> 61440 ±1 bclk_rise strobes (3.072 MHz); frame_start count = 960 ±1.
- Defaults, each mode, phase_inc = 2^31 -> pos-to-lrclk mapping:
  - mode 0: lrclk rises on the bclk_fall entering pos 31 and falls entering pos 63.
  - mode 1: rises entering pos 32, falls entering pos 0.
  - mode 2: high only during pos 63.
  - mode 3: identical to mode 1.
- Mode switch 1->0 mid-frame -> lrclk follows mode 1 until the next frame_start, then mode 0; locked drops and re-asserts after 2 frames.
- enable low at pos 17, held 5 cycles, then high -> idle values next cycle; on restart, first strobe is bclk_rise with slot_idx = 0 and bit_idx = 31; locked low until 2 frames.
- rst pulsed asynchronously (mid refclk period) at pos 40 -> outputs reach reset values before the next refclk edge; phase_inc change mid-run -> locked falls the next cycle, with no change in bclk continuity.
